key_press_filter: RTL and testbench



---
 rtl/key_press_filter_if.sv | 34 +++
 rtl/key_press_filter.sv | 120 ++++++++++++
 tb/tb_key_press_filter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/key_press_filter_if.sv
//==============================================================================
// key_press_filter_if : button pins in, debounced press pulses and levels out
// Revision 1.0
//==============================================================================
`default_nettype none

interface key_press_filter_if;
  logic [3:0] key_in;
  logic       key1_press;
  logic       key2_press;
  logic       key3_press;
  logic       key4_press;
  logic [3:0] key_state;

  modport slave (
    input  key_in,
    output key1_press,
    output key2_press,
    output key3_press,
    output key4_press,
    output key_state
  );

  modport master (
    output key_in,
    input  key1_press,
    input  key2_press,
    input  key3_press,
    input  key4_press,
    input  key_state
  );
endinterface

`default_nettype wire

// File: rtl/key_press_filter.sv
//==============================================================================
// key_press_filter : per-key 2-flop sync + debounce FSM, one-cycle press pulses
// Revision 1.0
//==============================================================================
`default_nettype none

module key_press_filter #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  key_press_filter_if.slave kif
);

  localparam int                c_CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic              c_RELEASED = KEY_ACTIVE_LOW;

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_PRESS_CNT   = 2'd1,
    S_HELD        = 2'd2,
    S_RELEASE_CNT = 2'd3
  } state_t;

  logic [3:0] w_press;
  logic [3:0] w_state;

  generate
    for (genvar i = 0; i < 4; i++) begin : g_key
      logic               sync1_q;
      logic               sync2_q;
      logic               w_pressed;
      state_t             state_q, state_d;
      logic [c_CNT_W-1:0] cnt_q, cnt_d;
      logic               press_q, press_d;

      // Synchronizer resets to the released level so a held key re-qualifies after reset
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync1_q <= c_RELEASED;
          sync2_q <= c_RELEASED;
          state_q <= S_IDLE;
          cnt_q   <= '0;
          press_q <= 1'b0;
        end else begin
          sync1_q <= kif.key_in[i];
          sync2_q <= sync1_q;
          state_q <= state_d;
          cnt_q   <= cnt_d;
          press_q <= press_d;
        end
      end

      assign w_pressed = sync2_q ^ KEY_ACTIVE_LOW;

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        unique case (state_q)
          S_IDLE: begin
            if (w_pressed) begin
              state_d = S_PRESS_CNT;
              cnt_d   = c_CNT_ONE;
            end
          end
          S_PRESS_CNT: begin
            if (!w_pressed) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else if (cnt_q == c_CNT_MAX) begin
              state_d = S_HELD;
              cnt_d   = '0;
              press_d = 1'b1;
            end else begin
              cnt_d   = cnt_q + c_CNT_ONE;
            end
          end
          S_HELD: begin
            if (!w_pressed) begin
              state_d = S_RELEASE_CNT;
              cnt_d   = c_CNT_ONE;
            end
          end
          S_RELEASE_CNT: begin
            // A bounce back to pressed returns to HELD silently: no second pulse
            if (w_pressed) begin
              state_d = S_HELD;
              cnt_d   = '0;
            end else if (cnt_q == c_CNT_MAX) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d   = cnt_q + c_CNT_ONE;
            end
          end
          default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        endcase
      end

      assign w_press[i] = press_q;
      assign w_state[i] = (state_q == S_HELD) || (state_q == S_RELEASE_CNT);
    end
  endgenerate

  assign kif.key1_press = w_press[0];
  assign kif.key2_press = w_press[1];
  assign kif.key3_press = w_press[2];
  assign kif.key4_press = w_press[3];
  assign kif.key_state  = w_state;

endmodule

`default_nettype wire

// File: tb/tb_key_press_filter.sv
//==============================================================================
// tb_key_press_filter : directed + random stimulus against a sliding-window model
// Revision 1.0
//==============================================================================
`default_nettype none

module tb_key_press_filter;
  localparam int DC = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_press_filter_if kif ();

  key_press_filter #(
    .DEBOUNCE_CYCLES(DC),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kif(kif.slave)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  // Model: a level flips once the last DC synchronized samples all disagree with it
  logic [3:0]    m_r1, m_r2, m_lvl, m_pulse;
  logic [DC-1:0] m_win [4];
  int            pcnt [4];
  int            pcyc [4];

  function automatic void model_reset();
    m_r1    = 4'hF;
    m_r2    = 4'hF;
    m_lvl   = 4'h0;
    m_pulse = 4'h0;
    for (int i = 0; i < 4; i++) m_win[i] = '0;
  endfunction

  function automatic void model_edge(input logic [3:0] raw);
    logic [3:0] seen;
    seen    = m_r2;
    m_r2    = m_r1;
    m_r1    = raw;
    m_pulse = 4'h0;
    for (int i = 0; i < 4; i++) begin
      m_win[i] = {m_win[i][DC-2:0], ~seen[i]};
      if (!m_lvl[i] && (&m_win[i])) begin
        m_lvl[i]   = 1'b1;
        m_pulse[i] = 1'b1;
      end else if (m_lvl[i] && !(|m_win[i])) begin
        m_lvl[i] = 1'b0;
      end
    end
  endfunction

  function automatic void clear_counts();
    for (int i = 0; i < 4; i++) begin
      pcnt[i] = 0;
      pcyc[i] = -1;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [3:0] press_vec();
    return {kif.key4_press, kif.key3_press, kif.key2_press, kif.key1_press};
  endfunction

  task automatic tick(input logic [3:0] k);
    logic [3:0] p;
    kif.key_in = k;
    @(posedge clk);
    cyc++;
    model_edge(k);
    #1;
    p = press_vec();
    check("press", 32'(p), 32'(m_pulse));
    check("state", 32'(kif.key_state), 32'(m_lvl));
    for (int i = 0; i < 4; i++) begin
      if (p[i] === 1'b1) begin
        pcnt[i]++;
        pcyc[i] = cyc;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] k);
    kif.key_in = k;
    rst = 1'b0;
    #1;
    check("rst_press", 32'(press_vec()), 32'h0);
    check("rst_state", 32'(kif.key_state), 32'h0);
    @(posedge clk);
    #1;
    check("rst_press_edge", 32'(press_vec()), 32'h0);
    check("rst_state_edge", 32'(kif.key_state), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int         n0;
    logic [3:0] cur;
    int         rem [4];

    rst        = 1'b0;
    kif.key_in = 4'hF;
    model_reset();
    clear_counts();
    @(negedge clk);
    do_reset(4'hF);

    // Clean press on key1, then release
    repeat (8) tick(4'hF);
    clear_counts();
    tick(4'hE);
    n0 = cyc;
    repeat (19) tick(4'hE);
    check("clean_pulses", 32'(pcnt[0]), 32'd1);
    check("clean_latency", 32'(pcyc[0]), 32'(n0 + 5));
    tick(4'hF);
    n0 = cyc;
    repeat (4) tick(4'hF);
    check("clean_still_held", 32'(kif.key_state), 32'h1);
    tick(4'hF);
    check("clean_released", 32'(kif.key_state), 32'h0);

    // Bounce on key2
    repeat (8) tick(4'hF);
    clear_counts();
    for (int j = 0; j < 8; j++) tick(((j / 2) % 2 == 0) ? 4'hD : 4'hF);
    tick(4'hD);
    n0 = cyc;
    repeat (11) tick(4'hD);
    check("bounce_pulses", 32'(pcnt[1]), 32'd1);
    check("bounce_latency", 32'(pcyc[1]), 32'(n0 + 5));

    // Short release on key3
    repeat (8) tick(4'hF);
    clear_counts();
    repeat (10) tick(4'hB);
    repeat (3) tick(4'hF);
    for (int j = 0; j < 10; j++) begin
      tick(4'hB);
      check("short_rel_state", 32'(kif.key_state[2]), 32'h1);
    end
    check("short_rel_pulses", 32'(pcnt[2]), 32'd1);

    // Simultaneous press of all keys
    repeat (8) tick(4'hF);
    clear_counts();
    repeat (8) tick(4'h0);
    for (int i = 0; i < 4; i++) check("simul_pulses", 32'(pcnt[i]), 32'd1);
    for (int i = 1; i < 4; i++) check("simul_same_cycle", 32'(pcyc[i]), 32'(pcyc[0]));
    check("simul_state", 32'(kif.key_state), 32'hF);

    // Reset mid-count on key4
    repeat (8) tick(4'hF);
    clear_counts();
    repeat (4) tick(4'h7);
    check("midrst_no_early", 32'(pcnt[3]), 32'd0);
    do_reset(4'h7);
    n0 = cyc;
    repeat (10) tick(4'h7);
    check("midrst_pulses", 32'(pcnt[3]), 32'd1);
    check("midrst_latency", 32'(pcyc[3]), 32'(n0 + 6));

    // One-cycle glitch on key1
    repeat (8) tick(4'hF);
    clear_counts();
    tick(4'hE);
    repeat (10) tick(4'hF);
    check("glitch_pulses", 32'(pcnt[0]), 32'd0);
    check("glitch_state", 32'(kif.key_state), 32'h0);

    // Random hold/bounce durations per key, occasional reset
    cur = 4'hF;
    for (int i = 0; i < 4; i++) rem[i] = $urandom_range(1, 9);
    for (int j = 0; j < 600; j++) begin
      for (int i = 0; i < 4; i++) begin
        if (rem[i] == 0) begin
          cur[i] = ~cur[i];
          rem[i] = $urandom_range(1, 9);
        end
        rem[i]--;
      end
      if ($urandom_range(0, 149) == 0) do_reset(cur);
      else tick(cur);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
